// File: rtl/alu_flag_pkg.sv
// Shared opcode, flag-index and flag-vector definitions for the ALU flag/result stage.
package alu_flag_pkg;

   localparam logic [2:0] SEL_ADD = 3'b000;
   localparam logic [2:0] SEL_SUB = 3'b001;

   localparam int FLAG_C = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 0;

   typedef logic [3:0] flags_t;

   // Signed overflow is only meaningful for the adder/subtractor opcodes.
   function automatic flags_t make_flags(input logic       c,
                                         input logic       z,
                                         input logic       n,
                                         input logic [2:0] sel,
                                         input logic       ovf);
      flags_t f;
      f         = '0;
      f[FLAG_C] = c;
      f[FLAG_Z] = z;
      f[FLAG_N] = n;
      f[FLAG_V] = ovf & ((sel == SEL_ADD) | (sel == SEL_SUB));
      return f;
   endfunction

endpackage

// File: rtl/flag_fifo2.sv
// Two-slot valid/ready buffer with explicit read/write pointers and occupancy count.
module flag_fifo2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] rdata_o,
   output logic [1:0]   count_o
);

   logic [W-1:0] slot0_q, slot1_q;
   logic         wptr_q, rptr_q;
   logic [1:0]   count_q, count_d;
   logic         push_ok, pop_ok;

   assign push_ok = push_i & (count_q != 2'd2);
   assign pop_ok  = pop_i  & (count_q != 2'd0);

   always_comb begin
      count_d = count_q;
      if (push_ok && !pop_ok)
         count_d = count_q + 2'd1;
      else if (!push_ok && pop_ok)
         count_d = count_q - 2'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot0_q <= '0;
         slot1_q <= '0;
         wptr_q  <= 1'b0;
         rptr_q  <= 1'b0;
         count_q <= 2'd0;
      end else begin
         if (push_ok) begin
            if (wptr_q) slot1_q <= wdata_i;
            else        slot0_q <= wdata_i;
            wptr_q <= ~wptr_q;
         end
         if (pop_ok)
            rptr_q <= ~rptr_q;
         count_q <= count_d;
      end
   end

   assign rdata_o = rptr_q ? slot1_q : slot0_q;
   assign count_o = count_q;

endmodule

// File: rtl/alu_flag_register.sv
// Registered ALU result/flag stage: derives {C,Z,N,V} at push, buffers two entries,
// and keeps sticky carry/overflow bits plus a saturating accepted-operation counter.
module alu_flag_register
   import alu_flag_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       sel,
   input  logic [WIDTH-1:0] result,
   input  logic             cout_flag,
   input  logic             ovf,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] q_result,
   output logic [3:0]       q_flags,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             sticky_c,
   output logic             sticky_v,
   output logic [CNT_W-1:0] op_count,
   input  logic             clr_stat
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]         count;
   logic               push, pop;
   flags_t             new_flags;
   logic [WIDTH+3:0]   wdata, rdata;
   logic               sticky_c_q, sticky_c_d;
   logic               sticky_v_q, sticky_v_d;
   logic [CNT_W-1:0]   op_count_q, op_count_d;

   // Handshake depends only on registered occupancy.
   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid  & in_ready;
   assign pop       = out_valid & out_ready;

   assign new_flags = make_flags(cout_flag, (result == '0), result[WIDTH-1], sel, ovf);
   assign wdata     = {new_flags, result};

   flag_fifo2 #(.W(WIDTH + 4)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (wdata),
      .rdata_o (rdata),
      .count_o (count)
   );

   // A push carrying the flag beats a simultaneous clear so the event is never lost.
   always_comb begin
      sticky_c_d = sticky_c_q;
      sticky_v_d = sticky_v_q;
      op_count_d = op_count_q;
      if (clr_stat) begin
         sticky_c_d = 1'b0;
         sticky_v_d = 1'b0;
         op_count_d = '0;
      end
      if (push) begin
         if (new_flags[FLAG_C]) sticky_c_d = 1'b1;
         if (new_flags[FLAG_V]) sticky_v_d = 1'b1;
         if (clr_stat)
            op_count_d = {{(CNT_W-1){1'b0}}, 1'b1};
         else if (op_count_q != CNT_MAX)
            op_count_d = op_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_c_q <= 1'b0;
         sticky_v_q <= 1'b0;
         op_count_q <= '0;
      end else begin
         sticky_c_q <= sticky_c_d;
         sticky_v_q <= sticky_v_d;
         op_count_q <= op_count_d;
      end
   end

   assign q_result = out_valid ? rdata[WIDTH-1:0]       : '0;
   assign q_flags  = out_valid ? rdata[WIDTH+3:WIDTH]   : 4'b0000;
   assign sticky_c = sticky_c_q;
   assign sticky_v = sticky_v_q;
   assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_flag_register.sv
// Randomised and directed bench for alu_flag_register against a queue-based reference model.
module tb_alu_flag_register;

   localparam int WIDTH = 4;
   localparam int CNT_W = 8;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [2:0]       sel;
   logic [WIDTH-1:0] result;
   logic             cout_flag, ovf, in_valid, out_ready, clr_stat;
   logic             in_ready, out_valid, sticky_c, sticky_v;
   logic [WIDTH-1:0] q_result;
   logic [3:0]       q_flags;
   logic [CNT_W-1:0] op_count;

   typedef struct packed {
      logic [WIDTH-1:0] r;
      logic [3:0]       f;
   } ent_t;

   ent_t mq[$];
   int   m_cnt;
   bit   m_sc, m_sv;
   int   n_chk = 0;
   int   n_err = 0;

   alu_flag_register #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .sel(sel), .result(result), .cout_flag(cout_flag),
      .ovf(ovf), .in_valid(in_valid), .in_ready(in_ready), .q_result(q_result),
      .q_flags(q_flags), .out_valid(out_valid), .out_ready(out_ready),
      .sticky_c(sticky_c), .sticky_v(sticky_v), .op_count(op_count), .clr_stat(clr_stat)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic check_all(input string tag);
      ent_t h;
      h = (mq.size() != 0) ? mq[0] : '0;
      chk({tag, "_in_ready"},  32'(in_ready),  32'(mq.size() != 2));
      chk({tag, "_out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
      chk({tag, "_q_result"},  32'(q_result),  32'(h.r));
      chk({tag, "_q_flags"},   32'(q_flags),   32'(h.f));
      chk({tag, "_sticky_c"},  32'(sticky_c),  32'(m_sc));
      chk({tag, "_sticky_v"},  32'(sticky_v),  32'(m_sv));
      chk({tag, "_op_count"},  32'(op_count),  32'(m_cnt));
   endtask

   task automatic drv(input bit v, input int s, input int r, input bit c, input bit o,
                      input bit ordy, input bit clr);
      in_valid  = v;
      sel       = 3'(s);
      result    = WIDTH'(r);
      cout_flag = c;
      ovf       = o;
      out_ready = ordy;
      clr_stat  = clr;
   endtask

   // Advance one clock with the currently driven inputs and update the model.
   task automatic cycle(input string tag);
      bit   mpush, mpop;
      ent_t e, dropped;
      int   rv;
      rv    = int'(result);
      mpush = in_valid && (mq.size() < 2);
      mpop  = (mq.size() > 0) && out_ready;
      e.r   = result;
      e.f   = {cout_flag, (rv == 0), (rv >= (1 << (WIDTH - 1))), (ovf && (sel <= 3'd1))};
      @(posedge clk);
      if (mpop) dropped = mq.pop_front();
      if (mpush) mq.push_back(e);
      if (mpush && e.f[3]) m_sc = 1;
      else if (clr_stat)   m_sc = 0;
      if (mpush && e.f[0]) m_sv = 1;
      else if (clr_stat)   m_sv = 0;
      if (clr_stat)                    m_cnt = mpush ? 1 : 0;
      else if (mpush && m_cnt < CMAX)  m_cnt = m_cnt + 1;
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic model_reset();
      mq.delete();
      m_cnt = 0;
      m_sc  = 0;
      m_sv  = 0;
   endtask

   initial begin
      rst_n = 1'b0;
      drv(0, 0, 0, 0, 0, 0, 0);
      model_reset();
      #13;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // ADD of zero with carry
      drv(1, 0, 0, 1, 0, 0, 0);
      cycle("tp1");
      chk("tp1_flags_const", 32'(q_flags), 32'b1100);
      chk("tp1_opcnt_const", 32'(op_count), 32'd1);
      drv(0, 0, 0, 0, 0, 1, 0);
      cycle("tp1_drain");

      // Three offers with consumer stalled, then drain in order
      drv(1, 0, 1, 0, 0, 0, 0); cycle("fill1");
      drv(1, 0, 2, 0, 0, 0, 0); cycle("fill2");
      chk("fill2_in_ready_const", 32'(in_ready), 32'd0);
      drv(1, 0, 3, 0, 0, 0, 0); cycle("fill3");
      drv(0, 0, 0, 0, 0, 1, 0);
      chk("pop1_const", 32'(q_result), 32'd1);
      cycle("pop1");
      chk("pop2_const", 32'(q_result), 32'd2);
      cycle("pop2");
      cycle("pop3");
      chk("empty_qres_const", 32'(q_result), 32'd0);

      // Unused opcode masks V; SUB does not
      drv(1, 2, 8, 0, 1, 1, 0); cycle("op010");
      chk("op010_flags_const", 32'(q_flags), 32'b0010);
      drv(1, 1, 5, 0, 1, 1, 0); cycle("sub_ovf");
      chk("sub_sticky_v_const", 32'(sticky_v), 32'd1);
      drv(0, 0, 0, 0, 0, 1, 0); cycle("drain_a");

      // Clear, then 20 cycles of streaming
      drv(0, 0, 0, 0, 0, 1, 1); cycle("clr_idle");
      for (int i = 0; i < 20; i++) begin
         drv(1, $urandom_range(0, 7), $urandom_range(0, 15), 0, 0, 1, 0);
         cycle("stream");
      end
      chk("stream_cnt_const", 32'(op_count), 32'd20);
      chk("stream_occ_const", 32'(out_valid && in_ready), 32'd1);

      // Clear coinciding with a carry push
      drv(1, 0, 7, 1, 0, 1, 1); cycle("clr_push");
      chk("clr_push_sc_const", 32'(sticky_c), 32'd1);
      chk("clr_push_cnt_const", 32'(op_count), 32'd1);

      // Saturation
      for (int i = 0; i < 300; i++) begin
         drv(1, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 1), 0, 1, 0);
         cycle("sat");
      end
      chk("sat_const", 32'(op_count), 32'd255);

      // Randomised traffic
      for (int i = 0; i < 600; i++) begin
         drv($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 15),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 2) != 0,
             $urandom_range(0, 9) == 0);
         cycle("rand");
      end

      // Asynchronous reset with the buffer full
      drv(1, 0, 9, 1, 1, 0, 0); cycle("prefill1");
      drv(1, 0, 6, 0, 0, 0, 0); cycle("prefill2");
      chk("prefill_full_const", 32'(in_ready), 32'd0);
      drv(0, 0, 0, 0, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      drv(1, 1, 4, 0, 0, 0, 0); cycle("post_rst");
      chk("post_rst_const", 32'(q_result), 32'd4);

      for (int i = 0; i < 200; i++) begin
         drv($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 15),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 15) == 0);
         cycle("rand2");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
